// File: rtl/rv_load_store_unit_if.sv
// Execute, data-bus and writeback signals of the load/store unit.
// The slave modport is the unit itself; master is whatever drives it.
interface rv_load_store_unit_if;
   logic        x_valid_i;
   logic        x_load_i;
   logic        x_store_i;
   logic [2:0]  x_fun_i;
   logic [31:0] x_addr_i;
   logic [31:0] x_store_data_i;
   logic        x_stall_i;
   logic        x_stall_req_o;
   logic        x_misaligned_o;
   logic [31:0] dm_addr_o;
   logic [31:0] dm_data_s_o;
   logic [3:0]  dm_data_select_o;
   logic        dm_load_o;
   logic        dm_store_o;
   logic        dm_ready_i;
   logic        dm_load_done_i;
   logic        dm_store_done_i;
   logic [31:0] dm_data_l_i;
   logic        w_load_o;
   logic [2:0]  w_fun_o;
   logic [31:0] w_dm_addr_o;
   logic [31:0] w_data_l_o;
   logic        w_valid_l_o;
   logic        bus_err_o;

   modport master (
      output x_valid_i, x_load_i, x_store_i, x_fun_i, x_addr_i, x_store_data_i, x_stall_i,
      output dm_ready_i, dm_load_done_i, dm_store_done_i, dm_data_l_i,
      input  x_stall_req_o, x_misaligned_o,
      input  dm_addr_o, dm_data_s_o, dm_data_select_o, dm_load_o, dm_store_o,
      input  w_load_o, w_fun_o, w_dm_addr_o, w_data_l_o, w_valid_l_o, bus_err_o
   );

   modport slave (
      input  x_valid_i, x_load_i, x_store_i, x_fun_i, x_addr_i, x_store_data_i, x_stall_i,
      input  dm_ready_i, dm_load_done_i, dm_store_done_i, dm_data_l_i,
      output x_stall_req_o, x_misaligned_o,
      output dm_addr_o, dm_data_s_o, dm_data_select_o, dm_load_o, dm_store_o,
      output w_load_o, w_fun_o, w_dm_addr_o, w_data_l_o, w_valid_l_o, bus_err_o
   );
endinterface

// File: rtl/rv_load_store_unit.sv
// Load/store stage: aligns address, lane-selects and replicates store data, drives data bus.
// Latency: strobe the cycle after accept; load word to writeback the cycle after done.
// Backpressure: one access in flight; stall request held until the state returns to IDLE.
module rv_load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                 clk_i,
   input logic                 rst_n_i,
   rv_load_store_unit_if.slave lsu
);
   typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT} state_t;

   state_t      state, state_nxt;
   logic [15:0] tmo_cnt;
   logic        req_any, misaligned, accept;
   logic        ld_state, st_state, ld_done, st_done, expired, tmo_hit;
   logic [3:0]  sel_nxt;
   logic [31:0] sdat_nxt;

   assign req_any  = lsu.x_valid_i & (lsu.x_load_i | lsu.x_store_i) & ~lsu.x_stall_i;
   assign misaligned = ((lsu.x_fun_i[1:0] == 2'b01) & lsu.x_addr_i[0]) |
                       ((lsu.x_fun_i[1:0] == 2'b10) & (lsu.x_addr_i[1:0] != 2'b00));
   assign accept   = (state == IDLE) & req_any & ~misaligned;
   assign ld_state = (state == LD_REQ) | (state == LD_WAIT);
   assign st_state = (state == ST_REQ) | (state == ST_WAIT);
   assign ld_done  = ((state == LD_REQ) & lsu.dm_ready_i & lsu.dm_load_done_i) |
                     ((state == LD_WAIT) & lsu.dm_load_done_i);
   assign st_done  = ((state == ST_REQ) & lsu.dm_ready_i & lsu.dm_store_done_i) |
                     ((state == ST_WAIT) & lsu.dm_store_done_i);
   assign expired  = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
   // A done landing on the expiry cycle wins over the timeout.
   assign tmo_hit  = expired & ((ld_state & ~ld_done) | (st_state & ~st_done));

   assign lsu.dm_load_o     = (state == LD_REQ);
   assign lsu.dm_store_o    = (state == ST_REQ);
   assign lsu.x_stall_req_o = (state != IDLE);
   assign lsu.w_load_o      = ld_state;

   always_comb begin
      sel_nxt  = 4'b1111;
      sdat_nxt = lsu.x_store_data_i;
      case (lsu.x_fun_i[1:0])
         2'b00: begin
            sel_nxt  = 4'b0001 << lsu.x_addr_i[1:0];
            sdat_nxt = {4{lsu.x_store_data_i[7:0]}};
         end
         2'b01: begin
            sel_nxt  = lsu.x_addr_i[1] ? 4'b1100 : 4'b0011;
            sdat_nxt = {2{lsu.x_store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = lsu.x_load_i ? LD_REQ : ST_REQ;
         LD_REQ:  if (ld_done || tmo_hit) state_nxt = IDLE;
                  else if (lsu.dm_ready_i) state_nxt = LD_WAIT;
         LD_WAIT: if (ld_done || tmo_hit) state_nxt = IDLE;
         ST_REQ:  if (st_done || tmo_hit) state_nxt = IDLE;
                  else if (lsu.dm_ready_i) state_nxt = ST_WAIT;
         ST_WAIT: if (st_done || tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         tmo_cnt              <= '0;
         lsu.x_misaligned_o   <= 1'b0;
         lsu.bus_err_o        <= 1'b0;
         lsu.w_valid_l_o      <= 1'b0;
         lsu.w_data_l_o       <= '0;
         lsu.dm_addr_o        <= '0;
         lsu.dm_data_s_o      <= '0;
         lsu.dm_data_select_o <= '0;
         lsu.w_fun_o          <= '0;
         lsu.w_dm_addr_o      <= '0;
      end else begin
         lsu.x_misaligned_o <= (state == IDLE) & req_any & misaligned;
         lsu.bus_err_o      <= tmo_hit;
         // A timed-out load still pulses valid so writeback is released.
         lsu.w_valid_l_o    <= ld_done | (tmo_hit & ld_state);
         if (ld_done)                 lsu.w_data_l_o <= lsu.dm_data_l_i;
         else if (tmo_hit & ld_state) lsu.w_data_l_o <= '0;
         if (accept) begin
            tmo_cnt              <= '0;
            lsu.dm_addr_o        <= {lsu.x_addr_i[31:2], 2'b00};
            lsu.dm_data_s_o      <= sdat_nxt;
            lsu.dm_data_select_o <= sel_nxt;
            lsu.w_fun_o          <= lsu.x_fun_i;
            lsu.w_dm_addr_o      <= lsu.x_addr_i;
         end else if (state != IDLE) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_rv_load_store_unit.sv
// Scoreboarded random/directed bench for rv_load_store_unit with a short timeout.
module tb_rv_load_store_unit;
   localparam int T = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   rv_load_store_unit_if bus_if ();

   rv_load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .lsu     (bus_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        ld;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] sd;
      logic [2:0]  fun;
      logic [31:0] baddr;
   } req_t;

   typedef struct {
      logic        vld;
      logic        err;
      logic        mis;
      logic [31:0] data;
      int          at;
   } ev_t;

   req_t req_q[$];
   ev_t  ev_q[$];
   int   run_q[$];

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int width_of(input logic [2:0] fun);
      case (fun)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [3:0] lanes_of(input logic [31:0] addr, input int bytes);
      int base;
      base = (int'(addr % 4) / bytes) * bytes;
      return 4'(((1 << bytes) - 1) << base);
   endfunction

   function automatic logic [31:0] replicate(input logic [31:0] d, input int bytes);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % bytes) +: 8];
      return r;
   endfunction

   function automatic logic [141:0] all_outputs();
      return {bus_if.x_stall_req_o, bus_if.x_misaligned_o, bus_if.dm_addr_o, bus_if.dm_data_s_o,
              bus_if.dm_data_select_o, bus_if.dm_load_o, bus_if.dm_store_o, bus_if.w_load_o,
              bus_if.w_fun_o, bus_if.w_dm_addr_o, bus_if.w_data_l_o, bus_if.w_valid_l_o,
              bus_if.bus_err_o};
   endfunction

   // ready at cycle r after accept, done at cycle r+d (d=0: with ready); never: no done at all.
   task automatic do_access(input bit ld, input bit st, input logic [2:0] fun,
                            input logic [31:0] addr, input logic [31:0] sd, input int stall_cyc,
                            input int r, input int d, input bit never, input int rst_at,
                            input logic [31:0] ld_word);
      int   bytes, c, end_k, p, guard;
      bit   mis, completes, done_now;
      req_t q;
      ev_t  e;
      @(negedge clk);
      bus_if.dm_ready_i      = 1'b0;
      bus_if.dm_load_done_i  = 1'b0;
      bus_if.dm_store_done_i = 1'b0;
      guard = 0;
      while (bus_if.x_stall_req_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard == 50) check("idle_wait_timeout", 1, 0);
      bytes     = width_of(fun);
      mis       = (addr % bytes) != 0;
      c         = r + d;
      completes = !never && (c <= T - 1);
      bus_if.x_valid_i      = 1'b1;
      bus_if.x_load_i       = ld;
      bus_if.x_store_i      = st;
      bus_if.x_fun_i        = fun;
      bus_if.x_addr_i       = addr;
      bus_if.x_store_data_i = sd;
      bus_if.x_stall_i      = (stall_cyc > 0);
      repeat (stall_cyc) @(negedge clk);
      bus_if.x_stall_i = 1'b0;
      p = cyc;
      if (mis) begin
         e = '{vld: 1'b0, err: 1'b0, mis: 1'b1, data: 32'h0, at: p + 1};
         ev_q.push_back(e);
         @(negedge clk);
         bus_if.x_valid_i      = 1'b0;
         bus_if.x_load_i       = 1'b0;
         bus_if.x_store_i      = 1'b0;
         bus_if.dm_load_done_i  = 1'b1;
         bus_if.dm_store_done_i = 1'b1;
         bus_if.dm_data_l_i     = $urandom;
         return;
      end
      q = '{ld: ld, addr: addr & 32'hFFFF_FFFC, sel: lanes_of(addr, bytes),
            sd: replicate(sd, bytes), fun: fun, baddr: addr};
      req_q.push_back(q);
      if (rst_at >= 0) begin
         run_q.push_back(rst_at + 1);
         end_k = rst_at;
      end else if (completes) begin
         run_q.push_back(c + 1);
         end_k = c;
         if (ld) begin
            e = '{vld: 1'b1, err: 1'b0, mis: 1'b0, data: ld_word, at: p + c + 2};
            ev_q.push_back(e);
         end
      end else begin
         run_q.push_back(T);
         end_k = T - 1;
         e = '{vld: ld, err: 1'b1, mis: 1'b0, data: 32'h0, at: p + T + 1};
         ev_q.push_back(e);
      end
      for (int k = 0; k <= end_k; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus_if.x_valid_i = 1'b0;
            bus_if.x_load_i  = 1'b0;
            bus_if.x_store_i = 1'b0;
         end
         done_now = !never && (k == c);
         bus_if.dm_ready_i = (k == r);
         if (ld) begin
            bus_if.dm_load_done_i  = done_now;
            bus_if.dm_store_done_i = 1'($urandom_range(1));
         end else begin
            bus_if.dm_store_done_i = done_now;
            bus_if.dm_load_done_i  = 1'($urandom_range(1));
         end
         bus_if.dm_data_l_i = done_now ? ld_word : $urandom;
         if (k == rst_at) rst_n = 1'b0;
      end
      if (rst_at >= 0) begin
         @(negedge clk);
         bus_if.dm_ready_i      = 1'b0;
         bus_if.dm_load_done_i  = 1'b0;
         bus_if.dm_store_done_i = 1'b0;
         check("outputs_after_mid_reset", 160'(all_outputs()), 0);
         rst_n = 1'b1;
         @(negedge clk);
         bus_if.dm_load_done_i = 1'b1;
         bus_if.dm_data_l_i    = 32'hBAD0_BAD0;
         @(negedge clk);
         bus_if.dm_load_done_i = 1'b0;
         check("late_done_ignored", {bus_if.w_valid_l_o, bus_if.x_stall_req_o}, 0);
      end
   endtask

   // Monitor: request strobes, writeback/error/misalign pulses and stall-run lengths.
   logic prev_strb = 1'b0;
   int   run = 0;
   initial begin
      req_t q;
      ev_t  e;
      forever begin
         @(negedge clk);
         if ((bus_if.dm_load_o | bus_if.dm_store_o) && !prev_strb) begin
            if (req_q.size() == 0) check("unexpected_strobe", 1, 0);
            else begin
               q = req_q.pop_front();
               check("request",
                     {bus_if.dm_load_o, bus_if.dm_store_o, bus_if.w_load_o, bus_if.dm_addr_o,
                      bus_if.dm_data_select_o, bus_if.dm_data_s_o, bus_if.w_fun_o, bus_if.w_dm_addr_o},
                     {q.ld, !q.ld, q.ld, q.addr, q.sel, q.sd, q.fun, q.baddr});
            end
         end
         prev_strb = bus_if.dm_load_o | bus_if.dm_store_o;
         if (bus_if.w_valid_l_o | bus_if.bus_err_o | bus_if.x_misaligned_o) begin
            if (ev_q.size() == 0)
               check("unexpected_event", {bus_if.w_valid_l_o, bus_if.bus_err_o, bus_if.x_misaligned_o}, 0);
            else begin
               e = ev_q.pop_front();
               check("event",
                     {bus_if.w_valid_l_o, bus_if.bus_err_o, bus_if.x_misaligned_o, bus_if.x_stall_req_o,
                      bus_if.w_load_o, bus_if.w_valid_l_o ? bus_if.w_data_l_o : 32'h0},
                     {e.vld, e.err, e.mis, 1'b0, 1'b0, e.data});
               check("event_cycle", cyc, e.at);
            end
         end
         if (bus_if.x_stall_req_o) run++;
         else if (run > 0) begin
            if (run_q.size() == 0) check("unexpected_stall_run", run, 0);
            else check("stall_run_length", run, run_q.pop_front());
            run = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit          ld, st, nv;
      logic [2:0]  fun;
      logic [31:0] addr;
      int          bytes;
      bus_if.x_valid_i = 1'b0; bus_if.x_load_i = 1'b0; bus_if.x_store_i = 1'b0;
      bus_if.x_fun_i = 3'b0; bus_if.x_addr_i = 32'h0; bus_if.x_store_data_i = 32'h0;
      bus_if.x_stall_i = 1'b0; bus_if.dm_ready_i = 1'b0; bus_if.dm_load_done_i = 1'b0;
      bus_if.dm_store_done_i = 1'b0; bus_if.dm_data_l_i = 32'h0;
      repeat (3) @(negedge clk);
      check("outputs_in_reset", 160'(all_outputs()), 0);
      rst_n = 1'b1;

      do_access(1, 0, 3'b010, 32'h0000_1000, 32'h0, 0, 0, 2, 0, -1, 32'hDEAD_BEEF);
      do_access(0, 1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 2, 1, 0, -1, 32'h0);
      do_access(1, 0, 3'b001, 32'h0000_3001, 32'h0, 0, 0, 0, 0, -1, 32'h0);
      do_access(1, 0, 3'b010, 32'h0000_5004, 32'h0, 0, 0, 0, 0, -1, 32'h1357_9BDF);
      do_access(0, 1, 3'b001, 32'h0000_4002, 32'h0000_1234, 0, 1, 1, 0, -1, 32'h0);
      do_access(1, 0, 3'b010, 32'h0000_6000, 32'h0, 0, 0, 0, 1, -1, 32'h0);
      do_access(1, 0, 3'b010, 32'h0000_6000, 32'h0, 0, 0, T - 1, 0, -1, 32'hCAFE_F00D);
      do_access(0, 1, 3'b010, 32'h0000_7000, 32'h1111_2222, 0, 3, 9, 0, -1, 32'h0);
      do_access(0, 1, 3'b010, 32'h0000_7010, 32'h3333_4444, 0, T - 1, 0, 0, -1, 32'h0);
      do_access(1, 1, 3'b100, 32'h0000_8001, 32'h7766_5544, 3, 1, 0, 0, -1, 32'h0000_0080);
      do_access(0, 1, 3'b010, 32'h0000_9002, 32'h0, 2, 0, 0, 0, -1, 32'h0);
      do_access(1, 0, 3'b010, 32'h0000_A000, 32'h0, 0, 0, 0, 1, 2, 32'h0);

      for (int i = 0; i < 60; i++) begin
         ld  = 1'($urandom_range(1));
         st  = !ld || ($urandom_range(3) == 0);
         if (ld) begin
            case ($urandom_range(4))
               0: fun = 3'b000; 1: fun = 3'b001; 2: fun = 3'b010; 3: fun = 3'b100; default: fun = 3'b101;
            endcase
         end else fun = 3'($urandom_range(2));
         bytes = width_of(fun);
         addr  = $urandom;
         if ($urandom_range(3) != 0) addr = addr - (addr % bytes);
         nv = ($urandom_range(7) == 0);
         do_access(ld, st, fun, addr, $urandom, ($urandom_range(4) == 0) ? 2 : 0,
                   $urandom_range(4), $urandom_range(5), nv, -1, $urandom);
      end

      @(negedge clk);
      bus_if.dm_ready_i = 1'b0; bus_if.dm_load_done_i = 1'b0; bus_if.dm_store_done_i = 1'b0;
      repeat (T + 4) @(negedge clk);
      check("pending_requests", req_q.size(), 0);
      check("pending_events", ev_q.size(), 0);
      check("pending_stall_runs", run_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
